// File: rtl/x_uart_rx_cfg.sv
// x_uart_rx_cfg - configurable UART receiver (5..8 data bits, none/odd/even
// parity, 1 or 2 stop bits) with start-bit glitch rejection and per-frame
// error reporting. Emits one status-qualified byte per received frame.
//
// Parameters:
//   p_clk_hz     core clock frequency in Hz
//   p_baud       line baud rate
//   p_data_bits  data bits per frame, 5..8
//   p_parity     0 = none, 1 = odd, 2 = even
//   p_stop_bits  stop bits, 1 or 2
//
// Ports:
//   i_clk          core clock, all logic on the rising edge
//   i_rst          synchronous active-high reset
//   i_rx           asynchronous serial input, idle high
//   o_valid        one-cycle pulse when a frame completes
//   o_data         received data, LSB-aligned, unused upper bits read 0
//   o_parity_err   parity mismatch on the last frame
//   o_frame_err    at least one stop bit sampled low on the last frame
//   o_break        last frame was all-zero data/parity with a frame error
//
// Handshake: o_valid is a single-cycle strobe with no back-pressure; o_data
// and the three flags change only in the o_valid cycle and hold until the
// next completion, so a consumer may sample them on or after the strobe.
//
// Build option: define X_UART_RX_MAJORITY_EN to replace the single sample
// at each bit point with a 3-sample majority vote around that point.
//
// The FSM state is held in 'state' (type state_t) for observation.

module x_uart_rx_cfg #(
  parameter int p_clk_hz    = 1200000,
  parameter int p_baud      = 115200,
  parameter int p_data_bits = 8,
  parameter int p_parity    = 0,
  parameter int p_stop_bits = 1
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_rx,
  output logic       o_valid,
  output logic [7:0] o_data,
  output logic       o_parity_err,
  output logic       o_frame_err,
  output logic       o_break
);

  localparam int T  = p_clk_hz / p_baud;
  localparam int H  = T / 2;
  localparam int TW = $clog2(T + 1);

  localparam logic [TW-1:0] T_W = TW'(T);
  localparam logic [TW-1:0] H_W = TW'(H);
  localparam logic [TW-1:0] ONE_W = TW'(1);
  localparam logic [2:0]    LAST_BIT  = 3'(p_data_bits - 1);
  localparam logic          LAST_STOP = 1'(p_stop_bits - 1);
  // Value that (data XOR parity bit) must take for a good frame.
  localparam logic          PAR_EXP   = (p_parity == 1);

  if (T < 4 || p_data_bits < 5 || p_data_bits > 8 || p_parity < 0 ||
      p_parity > 2 || p_stop_bits < 1 || p_stop_bits > 2) begin : g_cfg_err
    $error("x_uart_rx_cfg: unsupported parameter combination");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t        state, state_n;
  logic [TW-1:0] timer, timer_n;

  logic          sync1, rx_s, rx_prev;
  logic [2:0]    bit_cnt;
  logic          stop_cnt;
  logic [7:0]    shreg;
  logic          par_acc, par_bit, perr, ferr;

  logic          fall, sample_evt, samp;
  logic          clear_frame, take_data, take_par, take_stop, done;
  logic          ferr_final;

  assign fall = ~rx_s & rx_prev;

  // START samples at the half-bit point, every other state at a full bit.
  assign sample_evt = (state == S_START) ? (timer == H_W) :
                      (state != S_IDLE) && (timer == T_W);

`ifdef X_UART_RX_MAJORITY_EN
  // rx_prev is rx_s one cycle before the point and sync1 is the value rx_s
  // takes one cycle after it, so the vote spans point-1..point+1 while the
  // decision still lands on the sample-event cycle.
  assign samp = (rx_prev & rx_s) | (rx_prev & sync1) | (rx_s & sync1);
`else
  assign samp = rx_s;
`endif

  assign ferr_final = ferr | ~samp;

  always_comb begin
    state_n     = state;
    timer_n     = timer + ONE_W;
    clear_frame = 1'b0;
    take_data   = 1'b0;
    take_par    = 1'b0;
    take_stop   = 1'b0;
    done        = 1'b0;
    // The sample cycle is tick 0 of the following bit period, hence reload 1.
    if (sample_evt) timer_n = ONE_W;
    case (state)
      S_IDLE: begin
        timer_n = '0;
        // The fall cycle itself counts as tick 0 of the start bit.
        if (fall) begin
          state_n = S_START;
          timer_n = ONE_W;
        end
      end
      S_START: begin
        if (sample_evt) begin
          if (samp) begin
            state_n = S_IDLE;
            timer_n = '0;
          end else begin
            state_n     = S_DATA;
            clear_frame = 1'b1;
          end
        end
      end
      S_DATA: begin
        if (sample_evt) begin
          take_data = 1'b1;
          if (bit_cnt == LAST_BIT) state_n = (p_parity != 0) ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        if (sample_evt) begin
          take_par = 1'b1;
          state_n  = S_STOP;
        end
      end
      S_STOP: begin
        if (sample_evt) begin
          take_stop = 1'b1;
          if (stop_cnt == LAST_STOP) begin
            done    = 1'b1;
            state_n = S_IDLE;
            timer_n = '0;
          end
        end
      end
      default: begin
        state_n = S_IDLE;
        timer_n = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync1        <= 1'b1;
      rx_s         <= 1'b1;
      rx_prev      <= 1'b1;
      state        <= S_IDLE;
      timer        <= '0;
      bit_cnt      <= '0;
      stop_cnt     <= 1'b0;
      shreg        <= '0;
      par_acc      <= 1'b0;
      par_bit      <= 1'b0;
      perr         <= 1'b0;
      ferr         <= 1'b0;
      o_valid      <= 1'b0;
      o_data       <= '0;
      o_parity_err <= 1'b0;
      o_frame_err  <= 1'b0;
      o_break      <= 1'b0;
    end else begin
      sync1   <= i_rx;
      rx_s    <= sync1;
      rx_prev <= rx_s;
      state   <= state_n;
      timer   <= timer_n;
      o_valid <= done;

      if (clear_frame) begin
        bit_cnt  <= '0;
        stop_cnt <= 1'b0;
        shreg    <= '0;
        par_acc  <= 1'b0;
        par_bit  <= 1'b0;
        perr     <= 1'b0;
        ferr     <= 1'b0;
      end

      // Writing by index keeps data LSB-aligned for any width; bits above
      // p_data_bits stay at their cleared value of 0.
      if (take_data) begin
        shreg[bit_cnt] <= samp;
        par_acc        <= par_acc ^ samp;
        bit_cnt        <= bit_cnt + 3'd1;
      end

      if (take_par) begin
        par_bit <= samp;
        perr    <= ((par_acc ^ samp) != PAR_EXP);
      end

      if (take_stop) begin
        ferr     <= ferr_final;
        stop_cnt <= stop_cnt + 1'b1;
      end

      // The last stop sample is folded in directly so all outputs update
      // together on the cycle after it.
      if (done) begin
        o_data       <= shreg;
        o_parity_err <= perr;
        o_frame_err  <= ferr_final;
        o_break      <= (shreg == 8'h00) && !par_bit && ferr_final;
      end
    end
  end

endmodule
